link_channel_mux: RTL and testbench

LINK_CHANNEL_MUX -- requirements
Module: link_channel_mux

---
 rtl/link_channel_mux.sv | 140 ++++++++++++++
 tb/tb_link_channel_mux.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_channel_mux.sv
// Multiplexes per-channel codec samples onto one shared link with a valid/ready
// handshake, and demultiplexes received frames back into per-channel sample slots.
module link_channel_mux #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_strobe,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
    input  logic [NUM_CH-1:0]        ch_enable,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic [CH_W-1:0]          tx_ch,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic [CH_W-1:0]          rx_ch,
    input  logic                     rx_err_corrected,
    input  logic                     rx_err_fatal,
    output logic [NUM_CH*DATA_W-1:0] ch_data_out,
    output logic [NUM_CH-1:0]        ch_out_valid,
    output logic [CNT_W-1:0]         corr_count,
    output logic [CNT_W-1:0]         fatal_count,
    output logic                     overrun,
    output logic                     busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q;
    logic [NUM_CH-1:0]         pending_q;
    logic [NUM_CH-1:0]         pending_d;
    logic [NUM_CH*DATA_W-1:0]  shadow_q;
    logic                      tx_valid_q;
    logic [DATA_W-1:0]         tx_data_q;
    logic [CH_W-1:0]           tx_ch_q;
    logic                      overrun_q;
    logic [CH_W-1:0]           startCh;
    logic [CH_W-1:0]           nextCh;

    logic [NUM_CH*DATA_W-1:0]  ch_data_out_q;
    logic [NUM_CH-1:0]         ch_out_valid_q;
    logic [CNT_W-1:0]          corr_count_q;
    logic [CNT_W-1:0]          fatal_count_q;
    logic                      rxInRange;

    // Lowest-index set bit wins, so channels go out in ascending order.
    function automatic logic [CH_W-1:0] lowestSet(input logic [NUM_CH-1:0] mask);
        lowestSet = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) lowestSet = CH_W'(i);
        end
    endfunction

    always_comb begin
        pending_d          = pending_q;
        pending_d[tx_ch_q] = 1'b0;
        startCh            = lowestSet(ch_enable);
        nextCh             = lowestSet(pending_d);
    end

    // TX FSM: tx_valid is high for the whole of SEND, so a handshake there is just tx_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            shadow_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_ch_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_strobe && (|ch_enable)) begin
                        shadow_q   <= ch_data_in;
                        pending_q  <= ch_enable;
                        state_q    <= SEND;
                        tx_valid_q <= 1'b1;
                        tx_ch_q    <= startCh;
                        tx_data_q  <= ch_data_in[int'(startCh)*DATA_W +: DATA_W];
                    end
                end
                SEND: begin
                    if (sample_strobe) overrun_q <= 1'b1;
                    if (tx_ready) begin
                        pending_q <= pending_d;
                        if (pending_d == '0) begin
                            state_q    <= IDLE;
                            tx_valid_q <= 1'b0;
                        end else begin
                            tx_ch_q   <= nextCh;
                            tx_data_q <= shadow_q[int'(nextCh)*DATA_W +: DATA_W];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rxInRange = (int'(rx_ch) < NUM_CH);

    // RX path: a fatal frame keeps the old sample (concealment) and only bumps the fatal counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_data_out_q  <= '0;
            ch_out_valid_q <= '0;
            corr_count_q   <= '0;
            fatal_count_q  <= '0;
        end else begin
            ch_out_valid_q <= '0;
            if (rx_valid && rxInRange) begin
                if (rx_err_fatal) begin
                    if (fatal_count_q != '1) fatal_count_q <= fatal_count_q + CNT_W'(1);
                end else begin
                    ch_data_out_q[int'(rx_ch)*DATA_W +: DATA_W] <= rx_data;
                    ch_out_valid_q[rx_ch] <= 1'b1;
                    if (rx_err_corrected && (corr_count_q != '1)) begin
                        corr_count_q <= corr_count_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign tx_ch        = tx_ch_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q == SEND);
    assign ch_data_out  = ch_data_out_q;
    assign ch_out_valid = ch_out_valid_q;
    assign corr_count   = corr_count_q;
    assign fatal_count  = fatal_count_q;

endmodule

// File: tb/tb_link_channel_mux.sv
// Self-checking bench for link_channel_mux: scoreboard queues for TX handshakes and
// RX slot pulses, a table of RX frames, and hand-written TX/overrun/reset sequences.
module tb_link_channel_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_strobe;
    logic [71:0] ch_data_in;
    logic [2:0]  ch_enable;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] tx_data;
    logic [1:0]  tx_ch;
    logic        rx_valid;
    logic [23:0] rx_data;
    logic [1:0]  rx_ch;
    logic        rx_err_corrected;
    logic        rx_err_fatal;
    logic [71:0] ch_data_out;
    logic [2:0]  ch_out_valid;
    logic [1:0]  corr_count;
    logic [1:0]  fatal_count;
    logic        overrun;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [23:0] data;
    } item_t;

    typedef struct {
        logic [1:0]  ch;
        logic [23:0] data;
        logic        corr;
        logic        fatal;
        logic        accept;
        logic [1:0]  expCorr;
        logic [1:0]  expFatal;
    } rxVec_t;

    item_t       txQ[$];
    item_t       rxQ[$];
    item_t       monItem;
    logic [23:0] slotModel[3];
    rxVec_t      rxTable[12];

    link_channel_mux #(.NUM_CH(3), .DATA_W(24), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .sample_strobe(sample_strobe),
        .ch_data_in(ch_data_in), .ch_enable(ch_enable),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_ch(tx_ch),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ch(rx_ch),
        .rx_err_corrected(rx_err_corrected), .rx_err_fatal(rx_err_fatal),
        .ch_data_out(ch_data_out), .ch_out_valid(ch_out_valid),
        .corr_count(corr_count), .fatal_count(fatal_count),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input rxVec_t v);
        rx_valid         = 1'b1;
        rx_ch            = v.ch;
        rx_data          = v.data;
        rx_err_corrected = v.corr;
        rx_err_fatal     = v.fatal;
        if (v.accept) begin
            rxQ.push_back('{v.ch, v.data});
            slotModel[v.ch] = v.data;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_tx_valid"}, tx_valid, 0);
        checkOutput({tag, "_tx_data"}, tx_data, 0);
        checkOutput({tag, "_tx_ch"}, tx_ch, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
        checkOutput({tag, "_ch_data_out"}, ch_data_out, 0);
        checkOutput({tag, "_ch_out_valid"}, ch_out_valid, 0);
        checkOutput({tag, "_corr"}, corr_count, 0);
        checkOutput({tag, "_fatal"}, fatal_count, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        txQ.delete();
        rxQ.delete();
        for (int k = 0; k < 3; k++) slotModel[k] = '0;
    endtask

    // Scoreboard: every TX handshake and every RX pulse must match the oldest expected item.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            if (txQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL tx_unexpected actual ch=%0d data=%h required=no transfer", tx_ch, tx_data);
            end else begin
                monItem = txQ.pop_front();
                checkOutput("sb_tx_ch", tx_ch, monItem.ch);
                checkOutput("sb_tx_data", tx_data, monItem.data);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (ch_out_valid[k]) begin
                if (rxQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rx_unexpected_pulse actual ch=%0d required=no pulse", k);
                end else begin
                    monItem = rxQ.pop_front();
                    checkOutput("sb_rx_ch", k, monItem.ch);
                    checkOutput("sb_rx_slot", ch_data_out[k*24 +: 24], monItem.data);
                end
            end
        end
    end

    initial begin
        rxTable[0]  = '{2'd1, 24'hABCDEF, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        rxTable[1]  = '{2'd1, 24'h000001, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1};
        rxTable[2]  = '{2'd3, 24'h123456, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        rxTable[3]  = '{2'd3, 24'h654321, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1};
        rxTable[4]  = '{2'd0, 24'h000010, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1};
        rxTable[5]  = '{2'd2, 24'h000020, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1};
        rxTable[6]  = '{2'd0, 24'hDEAD00, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2};
        rxTable[7]  = '{2'd2, 24'h000030, 1'b1, 1'b0, 1'b1, 2'd3, 2'd2};
        rxTable[8]  = '{2'd1, 24'h000040, 1'b1, 1'b0, 1'b1, 2'd3, 2'd2};
        rxTable[9]  = '{2'd0, 24'h000050, 1'b1, 1'b0, 1'b1, 2'd3, 2'd2};
        rxTable[10] = '{2'd2, 24'hBAD001, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3};
        rxTable[11] = '{2'd2, 24'hBAD002, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3};

        reset = 1'b1; sample_strobe = 1'b0; ch_data_in = '0; ch_enable = '0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = '0; rx_ch = '0; rx_err_corrected = 1'b0; rx_err_fatal = 1'b0;
        for (int k = 0; k < 3; k++) slotModel[k] = '0;
        tick();
        tick();
        reset = 1'b0;
        checkResetState("rst");

        // Strobe with an empty enable mask starts nothing.
        ch_enable = 3'b000; ch_data_in = {3{24'h5A5A5A}}; tx_ready = 1'b1; sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        checkOutput("noen_valid", tx_valid, 0);
        checkOutput("noen_busy", busy, 0);
        checkOutput("noen_overrun", overrun, 0);
        tick();
        checkOutput("noen_valid2", tx_valid, 0);

        // All three channels back to back, with an RX frame running alongside.
        ch_data_in = {24'h333333, 24'h222222, 24'h111111}; ch_enable = 3'b111; sample_strobe = 1'b1;
        txQ.push_back('{2'd0, 24'h111111});
        txQ.push_back('{2'd1, 24'h222222});
        txQ.push_back('{2'd2, 24'h333333});
        applyStimulus('{2'd2, 24'h777777, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0});
        tick();
        sample_strobe = 1'b0; rx_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("seqA_valid", tx_valid, 1);
            checkOutput("seqA_ch", tx_ch, c);
            checkOutput("seqA_busy", busy, 1);
            tick();
        end
        checkOutput("seqA_valid_end", tx_valid, 0);
        checkOutput("seqA_busy_end", busy, 0);
        checkOutput("seqA_slot2", ch_data_out[48 +: 24], 24'h777777);

        // Mask 101 with back-pressure; input and mask changes after the strobe must not leak in.
        ch_data_in = {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}; ch_enable = 3'b101;
        tx_ready = 1'b0; sample_strobe = 1'b1;
        txQ.push_back('{2'd0, 24'hAAAAAA});
        txQ.push_back('{2'd2, 24'hCCCCCC});
        tick();
        sample_strobe = 1'b0; ch_data_in = {24'h999999, 24'h888888, 24'h444444}; ch_enable = 3'b010;
        for (int i = 0; i < 4; i++) begin
            checkOutput("seqB_hold_valid", tx_valid, 1);
            checkOutput("seqB_hold_ch", tx_ch, 0);
            checkOutput("seqB_hold_data", tx_data, 24'hAAAAAA);
            if (i == 3) tx_ready = 1'b1;
            tick();
        end
        checkOutput("seqB_ch2", tx_ch, 2);
        checkOutput("seqB_data2", tx_data, 24'hCCCCCC);
        tick();
        checkOutput("seqB_valid_end", tx_valid, 0);
        checkOutput("seqB_busy_end", busy, 0);

        // Strobe during the second SEND cycle is an overrun and changes nothing in flight.
        ch_data_in = {24'h333333, 24'h222222, 24'h111111}; ch_enable = 3'b111; sample_strobe = 1'b1;
        txQ.push_back('{2'd0, 24'h111111});
        txQ.push_back('{2'd1, 24'h222222});
        txQ.push_back('{2'd2, 24'h333333});
        tick();
        sample_strobe = 1'b0;
        checkOutput("seqC_ch0", tx_ch, 0);
        checkOutput("seqC_ovr0", overrun, 0);
        tick();
        checkOutput("seqC_ch1", tx_ch, 1);
        sample_strobe = 1'b1; ch_data_in = {3{24'hEEEEEE}}; ch_enable = 3'b001;
        tick();
        sample_strobe = 1'b0;
        checkOutput("seqC_overrun", overrun, 1);
        checkOutput("seqC_ch2", tx_ch, 2);
        checkOutput("seqC_data2", tx_data, 24'h333333);
        tick();
        checkOutput("seqC_valid_end", tx_valid, 0);
        tick();
        tick();
        checkOutput("seqC_overrun_sticky", overrun, 1);
        checkOutput("seqC_busy", busy, 0);
        doReset();
        checkResetState("rst2");

        // Strobe coinciding with the final handshake: overrun, and no restart.
        ch_data_in = {24'h0, 24'h0, 24'h444444}; ch_enable = 3'b001; tx_ready = 1'b1; sample_strobe = 1'b1;
        txQ.push_back('{2'd0, 24'h444444});
        tick();
        ch_data_in = {3{24'h123123}};
        checkOutput("seqD_valid", tx_valid, 1);
        checkOutput("seqD_ch", tx_ch, 0);
        tick();
        sample_strobe = 1'b0;
        checkOutput("seqD_valid_end", tx_valid, 0);
        checkOutput("seqD_busy", busy, 0);
        checkOutput("seqD_overrun", overrun, 1);
        tick();
        checkOutput("seqD_no_restart", tx_valid, 0);
        checkOutput("seqD_busy2", busy, 0);

        // RX frame table: counters saturate at 3 with the 2-bit counter width.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(rxTable[i]);
            tick();
            rx_valid = 1'b0;
            tick();
            checkOutput($sformatf("rx%0d_corr", i), corr_count, rxTable[i].expCorr);
            checkOutput($sformatf("rx%0d_fatal", i), fatal_count, rxTable[i].expFatal);
            checkOutput($sformatf("rx%0d_slots", i), ch_data_out, {slotModel[2], slotModel[1], slotModel[0]});
        end

        // Reset mid-SEND with two channels pending, colliding with a strobe and an RX frame.
        ch_data_in = {24'h666666, 24'h555555, 24'h111111}; ch_enable = 3'b110; tx_ready = 1'b0; sample_strobe = 1'b1;
        txQ.push_back('{2'd1, 24'h555555});
        txQ.push_back('{2'd2, 24'h666666});
        tick();
        sample_strobe = 1'b0;
        checkOutput("seqE_valid", tx_valid, 1);
        checkOutput("seqE_ch", tx_ch, 1);
        sample_strobe = 1'b1; ch_enable = 3'b111;
        rx_valid = 1'b1; rx_ch = 2'd0; rx_data = 24'h999999; rx_err_corrected = 1'b1; rx_err_fatal = 1'b0;
        doReset();
        sample_strobe = 1'b0; rx_valid = 1'b0; rx_err_corrected = 1'b0;
        checkResetState("seqE_rst");
        tx_ready = 1'b1;
        tick();
        checkResetState("seqE_after");

        checkOutput("txq_empty", txQ.size(), 0);
        checkOutput("rxq_empty", rxQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
